// File: rtl/mem_pkg.sv
// Shared encodings for the memory access controller: transfer sizes,
// FSM states, timeout counter width and the alignment rule.
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_ILL  = 2'b10,
        SIZE_WORD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RELEASE,
        ST_FAULT
    } state_e;

    localparam int TMO_W = 8;

    // True when the request cannot be issued: bad alignment or illegal size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SIZE_WORD: return (lsb != 2'b00);
            SIZE_HALF: return lsb[0];
            SIZE_BYTE: return 1'b0;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response bundle between the control unit, the controller and the RAM.
// master: the controller's view; slave: the environment (CPU side and RAM).
interface mem_access_ctrl_if #(parameter int ADDR_W = 9);

    // CPU / datapath side
    logic              start;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [1:0]        size;
    logic              signedLoad;
    logic              busy;
    logic              done;
    logic [31:0]       rdata;
    logic              misalignErr;
    logic              timeoutErr;

    // RAM side
    logic              memFuncActive;
    logic              memReadWrite;
    logic [ADDR_W-1:0] memAddress;
    logic [31:0]       memDataIn;
    logic [1:0]        memDataSize;
    logic [31:0]       memDataOut;
    logic              memFuncComplete;

    modport master (
        input  start, rw, addr, wdata, size, signedLoad,
        output busy, done, rdata, misalignErr, timeoutErr,
        output memFuncActive, memReadWrite, memAddress, memDataIn, memDataSize,
        input  memDataOut, memFuncComplete
    );

    modport slave (
        output start, rw, addr, wdata, size, signedLoad,
        input  busy, done, rdata, misalignErr, timeoutErr,
        input  memFuncActive, memReadWrite, memAddress, memDataIn, memDataSize,
        output memDataOut, memFuncComplete
    );

endinterface

// File: rtl/mem_load_align.sv
// Formats raw RAM read data into a load result: low byte/halfword,
// zero- or sign-extended; stale upper RAM bytes are discarded.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] word
);

    // Select and extend the addressed portion of the read data.
    always_comb begin
        // NOTE: default assignment first so no path leaves word unassigned (no latch).
        word = data;
        case (size)
            SIZE_HALF: word = {{16{sign_ext & data[15]}}, data[15:0]};
            SIZE_BYTE: word = {{24{sign_ext & data[7]}},  data[7:0]};
            default:   word = data;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the RAM memFuncActive/memFuncComplete handshake.
// One request per transaction: setup cycle, access with timeout, release.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int ADDR_W         = 9
) (
    input  logic               Clk,
    input  logic               Reset,
    mem_access_ctrl_if.master  bus
);

    state_e            state, state_nxt;

    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_size;
    logic              req_signed;

    logic [TMO_W-1:0]  tmo_cnt;
    logic              misalign_q;
    logic              timeout_q;
    logic [31:0]       rdata_q;
    logic [31:0]       load_word;

    logic              accept;
    logic              bad_req;
    logic              complete;
    logic              expire;

    assign accept   = (state == ST_IDLE) && bus.start;
    assign bad_req  = is_misaligned(bus.size, bus.addr[1:0]);
    assign complete = (state == ST_ACCESS) && bus.memFuncComplete;
    // Expiry is the last ACCESS cycle allowed without completion; a
    // completion in that same cycle takes priority.
    assign expire   = (state == ST_ACCESS) && !bus.memFuncComplete &&
                      (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (bus.start) state_nxt = bad_req ? ST_FAULT : ST_SETUP;
            ST_SETUP:   state_nxt = ST_ACCESS;
            ST_ACCESS:  if (complete || expire) state_nxt = ST_RELEASE;
            ST_RELEASE: state_nxt = ST_IDLE;
            ST_FAULT:   state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs; enable is high only in ACCESS so a reset edge drops it.
    always_comb begin
        bus.busy          = (state != ST_IDLE);
        bus.done          = (state == ST_RELEASE) || (state == ST_FAULT);
        bus.memFuncActive = (state == ST_ACCESS);
    end

    // RAM inputs come only from the captured request, stable through ACCESS.
    assign bus.memReadWrite = req_rw;
    assign bus.memAddress   = req_addr;
    assign bus.memDataIn    = req_wdata;
    assign bus.memDataSize  = req_size;
    assign bus.rdata        = rdata_q;
    assign bus.misalignErr  = misalign_q;
    assign bus.timeoutErr   = timeout_q;

    // Capture the request on an accepted start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            req_rw     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_size   <= '0;
            req_signed <= 1'b0;
        end else if (accept) begin
            req_rw     <= bus.rw;
            req_addr   <= bus.addr;
            req_wdata  <= bus.wdata;
            req_size   <= bus.size;
            req_signed <= bus.signedLoad;
        end
    end

    // Timeout counter: cleared on SETUP entry, counts incomplete ACCESS cycles.
    always_ff @(posedge Clk) begin
        if (Reset)                                        tmo_cnt <= '0;
        else if (accept && !bad_req)                      tmo_cnt <= '0;
        else if (state == ST_ACCESS && !bus.memFuncComplete) tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Error flags: cleared by each accepted start, held until the next one.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (accept) begin
            misalign_q <= bad_req;
            timeout_q  <= 1'b0;
        end else if (expire) begin
            timeout_q  <= 1'b1;
        end
    end

    // Load result register: updated only by a completed read.
    always_ff @(posedge Clk) begin
        if (Reset)                  rdata_q <= '0;
        else if (complete && !req_rw) rdata_q <= load_word;
    end

    mem_load_align u_align (
        .data     (bus.memDataOut),
        .size     (req_size),
        .sign_ext (req_signed),
        .word     (load_word)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a big-endian byte RAM model.
module tb_mem_access_ctrl;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    mem_access_ctrl_if #(.ADDR_W(9)) bus ();

    mem_access_ctrl #(.TIMEOUT_CYCLES(15), .ADDR_W(9)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.master)
    );

    typedef struct {
        logic        rw;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [31:0] rdata;
        logic        mis;
        logic        tmo;
        int          lat;
        int          act;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   act_m = 0;
    int   accept_cnt = 0;
    int   done_cnt = 0;

    // RAM model: resp_delay 0 = never complete, k = complete in ACCESS cycle k.
    bit [7:0]  ram [512];
    int        resp_delay = 1;
    int        ram_act = 0;
    logic [23:0] stale = 24'hFFFFFF;

    always_comb begin
        int a;
        a = int'(bus.memAddress);
        case (bus.memDataSize)
            2'b11:   bus.memDataOut = {ram[a], ram[(a+1)%512], ram[(a+2)%512], ram[(a+3)%512]};
            2'b01:   bus.memDataOut = {stale[23:8], ram[a], ram[(a+1)%512]};
            default: bus.memDataOut = {stale, ram[a]};
        endcase
        bus.memFuncComplete = bus.memFuncActive && (resp_delay != 0) && (ram_act == resp_delay - 1);
    end

    always @(posedge Clk) begin
        if (bus.memFuncActive && !bus.memFuncComplete) ram_act <= ram_act + 1;
        else                                           ram_act <= 0;
        if (bus.memFuncActive && bus.memFuncComplete && bus.memReadWrite) begin
            case (bus.memDataSize)
                2'b11: begin
                    ram[bus.memAddress]     <= bus.memDataIn[31:24];
                    ram[bus.memAddress + 1] <= bus.memDataIn[23:16];
                    ram[bus.memAddress + 2] <= bus.memDataIn[15:8];
                    ram[bus.memAddress + 3] <= bus.memDataIn[7:0];
                end
                2'b01: begin
                    ram[bus.memAddress]     <= bus.memDataIn[15:8];
                    ram[bus.memAddress + 1] <= bus.memDataIn[7:0];
                end
                default: ram[bus.memAddress] <= bus.memDataIn[7:0];
            endcase
        end
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
        else             passes++;
    endtask

    // Monitor: tracks acceptance, checks held RAM inputs and each done response.
    always @(negedge Clk) begin
        if (Reset) begin
            act_m = 0;
        end else begin
            if (bus.memFuncActive) begin
                act_m++;
                if (exp_q.size() > 0) begin
                    check("mem_rw",   32'(bus.memReadWrite), 32'(exp_q[0].rw));
                    check("mem_addr", 32'(bus.memAddress),   32'(exp_q[0].addr));
                    check("mem_size", 32'(bus.memDataSize),  32'(exp_q[0].size));
                    check("mem_din",  bus.memDataIn,         exp_q[0].wdata);
                end
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rdata",       bus.rdata,               e.rdata);
                    check("misalignErr", 32'(bus.misalignErr),    32'(e.mis));
                    check("timeoutErr",  32'(bus.timeoutErr),     32'(e.tmo));
                    check("latency",     32'(cyc - acc_cyc + 1),  32'(e.lat));
                    check("active_cycles", 32'(act_m),            32'(e.act));
                    check("active_at_done", 32'(bus.memFuncActive), 32'd0);
                end
                done_cnt++;
            end
            if (bus.start && !bus.busy) begin
                acc_cyc = cyc + 1;
                act_m = 0;
                accept_cnt++;
            end
        end
    end

    task automatic wait_done(input int target);
        for (int i = 0; i < 100 && done_cnt < target; i++) @(posedge Clk);
        check("done_within_budget", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic do_op(input logic rw, input logic [8:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sgn, input logic [31:0] rdata,
                         input logic mis, input logic tmo, input int lat, input int act);
        exp_t e;
        int   target;
        target = done_cnt + 1;
        e = '{rw: rw, addr: addr, wdata: wdata, size: size, rdata: rdata,
              mis: mis, tmo: tmo, lat: lat, act: act};
        exp_q.push_back(e);
        @(posedge Clk); #1;
        bus.rw = rw; bus.addr = addr; bus.wdata = wdata; bus.size = size;
        bus.signedLoad = sgn; bus.start = 1'b1;
        @(posedge Clk); #1;
        bus.start = 1'b0;
        wait_done(target);
        @(posedge Clk); #1;
    endtask

    initial begin
        int base;
        int d0;
        int stage;
        Reset = 1'b1;
        bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0;
        bus.size = 2'b00; bus.signedLoad = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;

        // Reset values.
        check("rst_busy",   32'(bus.busy),          32'd0);
        check("rst_done",   32'(bus.done),          32'd0);
        check("rst_rdata",  bus.rdata,              32'd0);
        check("rst_mis",    32'(bus.misalignErr),   32'd0);
        check("rst_tmo",    32'(bus.timeoutErr),    32'd0);
        check("rst_active", 32'(bus.memFuncActive), 32'd0);

        // Reset in the middle of ACCESS: enable drops at that edge, no done.
        resp_delay = 0;
        @(posedge Clk); #1;
        bus.rw = 1'b1; bus.addr = 9'd8; bus.wdata = 32'h11223344; bus.size = 2'b11;
        bus.start = 1'b1;
        @(posedge Clk); #1 bus.start = 1'b0;
        @(posedge Clk); #1;
        check("mid_access_active", 32'(bus.memFuncActive), 32'd1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        check("reset_edge_active", 32'(bus.memFuncActive), 32'd0);
        check("reset_edge_done",   32'(bus.done),          32'd0);
        check("reset_edge_busy",   32'(bus.busy),          32'd0);
        check("reset_edge_addr",   32'(bus.memAddress),    32'd0);
        Reset = 1'b0;
        resp_delay = 1;

        // Zero-wait word store then load.
        do_op(1'b1, 9'd4, 32'hDEADBEEF, 2'b11, 1'b0, 32'h00000000, 1'b0, 1'b0, 3, 1);
        do_op(1'b0, 9'd4, 32'h0,        2'b11, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 3, 1);
        // Byte 0x80 at addr 5; loads with stale upper bytes.
        do_op(1'b1, 9'd5, 32'h00000080, 2'b00, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 3, 1);
        do_op(1'b0, 9'd5, 32'h0,        2'b00, 1'b0, 32'h00000080, 1'b0, 1'b0, 3, 1);
        do_op(1'b0, 9'd5, 32'h0,        2'b00, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 3, 1);
        // Signed halfword load at addr 6 (0xBEEF).
        do_op(1'b0, 9'd6, 32'h0,        2'b01, 1'b1, 32'hFFFFBEEF, 1'b0, 1'b0, 3, 1);
        // Faults: misaligned halfword, illegal size.
        do_op(1'b0, 9'd3, 32'h0,        2'b01, 1'b0, 32'hFFFFBEEF, 1'b1, 1'b0, 1, 0);
        do_op(1'b0, 9'd0, 32'h0,        2'b10, 1'b0, 32'hFFFFBEEF, 1'b1, 1'b0, 1, 0);
        // Timeout: RAM never completes.
        resp_delay = 0;
        do_op(1'b0, 9'd4, 32'h0,        2'b11, 1'b0, 32'hFFFFBEEF, 1'b0, 1'b1, 17, 15);
        // Completion in the last allowed ACCESS cycle wins.
        resp_delay = 15;
        do_op(1'b0, 9'd4, 32'h0,        2'b11, 1'b0, 32'hDE80BEEF, 1'b0, 1'b0, 17, 15);
        resp_delay = 1;
        // Halfword store 0x1234 at addr 6.
        do_op(1'b1, 9'd6, 32'h00001234, 2'b01, 1'b0, 32'hDE80BEEF, 1'b0, 1'b0, 3, 1);

        // start held high across three loads; inputs change after each acceptance.
        base = accept_cnt;
        d0 = done_cnt;
        stage = 0;
        exp_q.push_back('{rw: 1'b0, addr: 9'd4, wdata: 32'h0, size: 2'b11, rdata: 32'hDE801234,
                          mis: 1'b0, tmo: 1'b0, lat: 3, act: 1});
        exp_q.push_back('{rw: 1'b0, addr: 9'd5, wdata: 32'h0, size: 2'b00, rdata: 32'hFFFFFF80,
                          mis: 1'b0, tmo: 1'b0, lat: 3, act: 1});
        exp_q.push_back('{rw: 1'b0, addr: 9'd4, wdata: 32'h0, size: 2'b01, rdata: 32'h0000DE80,
                          mis: 1'b0, tmo: 1'b0, lat: 3, act: 1});
        @(posedge Clk); #1;
        bus.rw = 1'b0; bus.addr = 9'd4; bus.wdata = 32'h0; bus.size = 2'b11;
        bus.signedLoad = 1'b0; bus.start = 1'b1;
        for (int i = 0; i < 100 && stage < 3; i++) begin
            @(posedge Clk); #1;
            if (stage == 0 && accept_cnt == base + 1) begin
                bus.addr = 9'd5; bus.size = 2'b00; bus.signedLoad = 1'b1; stage = 1;
            end else if (stage == 1 && accept_cnt == base + 2) begin
                bus.addr = 9'd4; bus.size = 2'b01; bus.signedLoad = 1'b0; stage = 2;
            end else if (stage == 2 && accept_cnt == base + 3) begin
                bus.start = 1'b0; stage = 3;
            end
        end
        bus.start = 1'b0;
        wait_done(d0 + 3);
        repeat (3) @(posedge Clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the byte-addressed 512x8 RAM's memFuncActive/memFuncComplete handshake.
- Accepts one load/store request per transaction from the datapath (MAR/MDR side).
- Drives the RAM's function, address, size and write-data inputs; waits for completion with a timeout.
- Returns zero- or sign-extended load data plus a done pulse and error flags to the control unit.

Parameters:
- TIMEOUT_CYCLES, 15, max ACCESS cycles without memFuncComplete before abort (1..255).
- ADDR_W, 9, memory address width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- rw  in  1  1=write (store), 0=read (load).
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data; byte in [7:0], halfword in [15:0].
- size  in  2  11=word, 01=halfword, 00=byte, 10=illegal.
- signedLoad  in  1  1=sign-extend byte/halfword loads.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  formatted load result.
- misalignErr  out  1  alignment or illegal-size fault.
- timeoutErr  out  1  RAM did not complete in time.
- memFuncActive  out  1  RAM function enable.
- memReadWrite  out  1  to RAM readWrite.
- memAddress  out  ADDR_W  to RAM address.
- memDataIn  out  32  to RAM dataIn (= wdata, unmodified).
- memDataSize  out  2  to RAM dataSize.
- memDataOut  in  32  from RAM dataOut.
- memFuncComplete  in  1  from RAM.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM to IDLE; timeout counter cleared.
  - Reset mid-transaction drops memFuncActive at that same edge; no done pulse.
- FSM states:
  - IDLE -> SETUP on start, when access is legal.
  - IDLE -> FAULT on start, when misaligned or size=10.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> RELEASE on memFuncComplete, or on timeout.
  - RELEASE -> IDLE.
  - FAULT -> IDLE.
- Request capture: start latches rw, addr, wdata, size and signedLoad into internal registers; mem* outputs come only from these registers.
- SETUP: memReadWrite, memAddress, memDataSize and memDataIn are driven with memFuncActive=0, so the RAM sees stable inputs before its enable rises.
- ACCESS:
  - memFuncActive=1; mem* inputs held constant, because the responder re-triggers on any readWrite change.
  - memFuncComplete is sampled at the end of every ACCESS cycle, including the first; the responder may complete in zero time.
  - A minimum of one full ACCESS cycle always occurs.
- Completion: on memFuncComplete=1 in ACCESS, a read registers rdata from memDataOut:
  - word: memDataOut[31:0].
  - halfword: memDataOut[15:0], extended per signedLoad.
  - byte: memDataOut[7:0], extended per signedLoad.
  - Upper bytes from the RAM on sub-word reads are ignored (stale).
  - Writes leave rdata unchanged.
- RELEASE:
  - memFuncActive=0, done=1 for exactly this cycle.
  - Guarantees at least one low cycle between transactions, so every access presents a fresh rising edge of memFuncActive.
- Latency: start high at edge N → SETUP in cycle N+1, ACCESS in N+2, done in N+3 (zero-wait RAM), IDLE in N+4.
- busy = 1 in SETUP, ACCESS, RELEASE and FAULT.
- start is ignored unless in IDLE; no queuing.
- Alignment rules:
  - word requires addr[1:0]=00.
  - halfword requires addr[0]=0.
  - byte is always legal.
  - Aligned accesses never wrap past address 511.
- FAULT:
  - No memory access; memFuncActive stays 0.
  - done=1 and misalignErr=1 in cycle N+1.
- Timeout:
  - 8-bit counter cleared on SETUP entry, incremented each ACCESS cycle without completion.
  - When it reaches TIMEOUT_CYCLES → RELEASE with timeoutErr=1; rdata unchanged.
  - A completion arriving in the same cycle as expiry wins; no error.
- Error flags: valid with done; held until the next accepted start, which clears both.
- Memory byte order: big-endian, memDataIn[31:24] at addr.

Decomposition:
- mem_pkg:
  - size encodings SIZE_WORD=2'b11, SIZE_HALF=2'b01, SIZE_BYTE=2'b00.
  - FSM state encodings.
  - TIMEOUT counter width.
- Sub-module mem_load_align: combinational size/signedLoad extension of memDataOut → formatted load word; instantiated once.

Test Plan:
- Reset mid-ACCESS (write to addr 8) → memFuncActive 0 at the reset edge; no done; next start proceeds normally.
- Word store 0xDEADBEEF to addr 4, then word load addr 4 (bench RAM model, zero-wait) → each op: done at N+3, memFuncActive high exactly 1 cycle, rdata=0xDEADBEEF.
- Byte load addr 5 holding 0x80, memDataOut[31:8]=0xFFFFFF stale:
  - signedLoad=0 → rdata=0x00000080.
  - signedLoad=1 → rdata=0xFFFFFF80.
- Halfword load addr 3 → FAULT: done and misalignErr at N+1, memFuncActive never asserted; size=10 at addr 0 → same.
- Model withholds memFuncComplete → timeoutErr with done after 15 ACCESS cycles, memFuncActive low in RELEASE.
- Completion delayed to ACCESS cycle 15 → no error.
- start held high continuously for 3 loads → three transactions, each separated by ≥1 cycle with memFuncActive=0; start ignored while busy.
